// File: rtl/ctrl_divisao.sv
// Sequencing controller for a restoring 16-bit unsigned divider, one quotient bit per cycle.
// Optional divide-by-zero short path enabled by defining CTRL_DIV_ZERO_CHECK_EN.
module ctrl_divisao #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             resetDiv_n,
   input  logic             Inicio,
   input  logic [WIDTH-1:0] dividendo,
   input  logic [WIDTH-1:0] divisor,
   output logic             Ocupado,
   output logic             Fim,
   output logic             ErroDiv0,
   output logic             EnResto,
   output logic             EnQuociente,
   output logic [WIDTH-1:0] resto,
   output logic [WIDTH-1:0] quociente
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      StOcioso,
      StCarrega,
      StDivide,
      StEscreve,
      StFim
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic [WIDTH-1:0]  d_q, d_d;
   logic [WIDTH:0]    r_q, r_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              zero_q, zero_d;
   logic [WIDTH-1:0]  quoc_q, quoc_d;
   logic [WIDTH-1:0]  resto_q, resto_d;
   logic              ocup_q, fim_q, err_q, en_q;
   logic [WIDTH+1:0]  diff;

   // One extra bit beyond R so the sign of the trial subtraction is explicit.
   assign diff = {r_q, q_q[WIDTH-1]} - {2'b00, d_q};

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      d_d     = d_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      quoc_d  = quoc_q;
      resto_d = resto_q;
      unique case (state_q)
         StOcioso: begin
            if (Inicio) begin
               q_d     = dividendo;
               d_d     = divisor;
               zero_d  = 1'b0;
               state_d = StCarrega;
            end
         end
         StCarrega: begin
            r_d     = '0;
            cnt_d   = '0;
            state_d = StDivide;
`ifdef CTRL_DIV_ZERO_CHECK_EN
            if (d_q == '0) begin
               zero_d  = 1'b1;
               quoc_d  = '1;
               resto_d = q_q;
               state_d = StEscreve;
            end
`endif
         end
         StDivide: begin
            if (!diff[WIDTH+1]) begin
               r_d = diff[WIDTH:0];
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
               quoc_d  = q_d;
               resto_d = r_d[WIDTH-1:0];
               state_d = StEscreve;
            end
         end
         StEscreve: state_d = StFim;
         StFim:     state_d = StOcioso;
         default:   state_d = StOcioso;
      endcase
   end

   // Status outputs are registered from the next state so they align with the state cycle.
   always_ff @(posedge clk) begin
      if (!resetDiv_n) begin
         state_q <= StOcioso;
         q_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         quoc_q  <= '0;
         resto_q <= '0;
         ocup_q  <= 1'b0;
         fim_q   <= 1'b0;
         err_q   <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         d_q     <= d_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         quoc_q  <= quoc_d;
         resto_q <= resto_d;
         ocup_q  <= (state_d != StOcioso);
         fim_q   <= (state_d == StFim);
         err_q   <= (state_d == StFim) && zero_d;
         en_q    <= (state_d == StEscreve);
      end
   end

   assign Ocupado     = ocup_q;
   assign Fim         = fim_q;
   assign EnResto     = en_q;
   assign EnQuociente = en_q;
   assign resto       = resto_q;
   assign quociente   = quoc_q;
`ifdef CTRL_DIV_ZERO_CHECK_EN
   assign ErroDiv0    = err_q;
`else
   assign ErroDiv0    = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_divisao.sv
// Directed self-checking bench for ctrl_divisao; expectations follow CTRL_DIV_ZERO_CHECK_EN.
module tb_ctrl_divisao;

   logic        clk;
   logic        resetDiv_n;
   logic        Inicio;
   logic [15:0] dividendo;
   logic [15:0] divisor;
   logic        Ocupado;
   logic        Fim;
   logic        ErroDiv0;
   logic        EnResto;
   logic        EnQuociente;
   logic [15:0] resto;
   logic [15:0] quociente;

   int tests;
   int failed;

   int          en_cycle, fim_cycle, fim_count, en_count, ocup_bad, strobe_bad;
   logic [15:0] got_q, got_r;
   logic        got_err;

   ctrl_divisao #(.WIDTH(16)) dut (
      .clk         (clk),
      .resetDiv_n  (resetDiv_n),
      .Inicio      (Inicio),
      .dividendo   (dividendo),
      .divisor     (divisor),
      .Ocupado     (Ocupado),
      .Fim         (Fim),
      .ErroDiv0    (ErroDiv0),
      .EnResto     (EnResto),
      .EnQuociente (EnQuociente),
      .resto       (resto),
      .quociente   (quociente)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one request and records what the DUT does; cycle n is the period after edge n-1.
   task automatic run_op(input logic [15:0] dvd, input logic [15:0] dvs, input bit hold,
                         input int extra);
      en_cycle = 0; fim_cycle = 0; fim_count = 0; en_count = 0;
      ocup_bad = 0; strobe_bad = 0; got_q = 'x; got_r = 'x; got_err = 'x;
      @(negedge clk);
      Inicio = 1'b1; dividendo = dvd; divisor = dvs;
      @(posedge clk);
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (Ocupado !== (fim_cycle == 0)) ocup_bad++;
         if (EnResto !== EnQuociente) strobe_bad++;
         if (ErroDiv0 === 1'b1 && Fim !== 1'b1) strobe_bad++;
         if (EnResto === 1'b1) begin
            en_count++;
            if (en_cycle == 0) begin
               en_cycle = c; got_q = quociente; got_r = resto;
            end
         end
         if (Fim === 1'b1) begin
            fim_count++;
            if (fim_cycle == 0) begin
               fim_cycle = c; got_err = ErroDiv0;
            end
         end
         if (hold && c < 10) begin
            Inicio = 1'b1; dividendo = 16'h1111; divisor = 16'h0000;
         end else begin
            Inicio = 1'b0;
         end
         if (fim_cycle != 0 && c >= fim_cycle + extra) break;
      end
      Inicio = 1'b0;
   endtask

   task automatic test_reset();
      resetDiv_n = 1'b0; Inicio = 1'b1; dividendo = 16'd9; divisor = 16'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++; if (Ocupado !== 1'b0) begin failed++; $display("FAIL reset_ocupado got %b want 0", Ocupado); end
      tests++; if (Fim !== 1'b0) begin failed++; $display("FAIL reset_fim got %b want 0", Fim); end
      tests++; if (ErroDiv0 !== 1'b0) begin failed++; $display("FAIL reset_err got %b want 0", ErroDiv0); end
      tests++; if ({EnResto, EnQuociente} !== 2'b00) begin
         failed++; $display("FAIL reset_strobes got %b want 00", {EnResto, EnQuociente});
      end
      tests++; if (quociente !== 16'h0 || resto !== 16'h0) begin
         failed++; $display("FAIL reset_data got q=%h r=%h want 0/0", quociente, resto);
      end
      Inicio = 1'b0;
      resetDiv_n = 1'b1;
      repeat (2) @(negedge clk);
      tests++; if (Ocupado !== 1'b0) begin failed++; $display("FAIL idle_ocupado got %b want 0", Ocupado); end
   endtask

   task automatic test_basic();
      run_op(16'd100, 16'd7, 1'b0, 3);
      tests++; if (en_cycle !== 18) begin failed++; $display("FAIL basic_en_cycle got %0d want 18", en_cycle); end
      tests++; if (got_q !== 16'd14) begin failed++; $display("FAIL basic_quoc got %0d want 14", got_q); end
      tests++; if (got_r !== 16'd2) begin failed++; $display("FAIL basic_resto got %0d want 2", got_r); end
      tests++; if (fim_cycle !== 19) begin failed++; $display("FAIL basic_fim_cycle got %0d want 19", fim_cycle); end
      tests++; if (got_err !== 1'b0) begin failed++; $display("FAIL basic_err got %b want 0", got_err); end
      tests++; if (en_count !== 1 || fim_count !== 1) begin
         failed++; $display("FAIL basic_pulses got en=%0d fim=%0d want 1/1", en_count, fim_count);
      end
      tests++; if (ocup_bad !== 0 || strobe_bad !== 0) begin
         failed++; $display("FAIL basic_handshake got ocup_bad=%0d strobe_bad=%0d want 0/0", ocup_bad, strobe_bad);
      end
      tests++; if (quociente !== 16'd14 || resto !== 16'd2) begin
         failed++; $display("FAIL basic_hold got q=%0d r=%0d want 14/2", quociente, resto);
      end
   endtask

   task automatic test_wide_divisor();
      run_op(16'hFFFF, 16'h8001, 1'b0, 0);
      tests++; if (got_q !== 16'h0001) begin failed++; $display("FAIL wide_quoc got %h want 0001", got_q); end
      tests++; if (got_r !== 16'h7FFE) begin failed++; $display("FAIL wide_resto got %h want 7ffe", got_r); end
      tests++; if (fim_cycle !== 19) begin failed++; $display("FAIL wide_fim_cycle got %0d want 19", fim_cycle); end
   endtask

   task automatic test_back_to_back();
      run_op(16'd5, 16'd9, 1'b0, 0);
      tests++; if (got_q !== 16'd0 || got_r !== 16'd5) begin
         failed++; $display("FAIL b2b_first got q=%0d r=%0d want 0/5", got_q, got_r);
      end
      run_op(16'hFFFF, 16'd1, 1'b0, 0);
      tests++; if (ocup_bad !== 0) begin failed++; $display("FAIL b2b_accept got ocup_bad=%0d want 0", ocup_bad); end
      tests++; if (fim_cycle !== 19) begin failed++; $display("FAIL b2b_fim_cycle got %0d want 19", fim_cycle); end
      tests++; if (got_q !== 16'hFFFF || got_r !== 16'h0) begin
         failed++; $display("FAIL b2b_second got q=%h r=%h want ffff/0000", got_q, got_r);
      end
   endtask

   task automatic test_div_zero();
      int   exp_fim;
      logic exp_err;
`ifdef CTRL_DIV_ZERO_CHECK_EN
      exp_fim = 3;  exp_err = 1'b1;
`else
      exp_fim = 19; exp_err = 1'b0;
`endif
      run_op(16'd1234, 16'd0, 1'b0, 2);
      tests++; if (fim_cycle !== exp_fim) begin
         failed++; $display("FAIL zero_fim_cycle got %0d want %0d", fim_cycle, exp_fim);
      end
      tests++; if (en_cycle !== exp_fim - 1) begin
         failed++; $display("FAIL zero_en_cycle got %0d want %0d", en_cycle, exp_fim - 1);
      end
      tests++; if (got_err !== exp_err) begin failed++; $display("FAIL zero_err got %b want %b", got_err, exp_err); end
      tests++; if (got_q !== 16'hFFFF || got_r !== 16'd1234) begin
         failed++; $display("FAIL zero_data got q=%h r=%0d want ffff/1234", got_q, got_r);
      end
      tests++; if (ocup_bad !== 0 || strobe_bad !== 0) begin
         failed++; $display("FAIL zero_handshake got ocup_bad=%0d strobe_bad=%0d want 0/0", ocup_bad, strobe_bad);
      end
   endtask

   task automatic test_hold_inicio();
      run_op(16'd200, 16'd3, 1'b1, 25);
      tests++; if (got_q !== 16'd66 || got_r !== 16'd2) begin
         failed++; $display("FAIL hold_data got q=%0d r=%0d want 66/2", got_q, got_r);
      end
      tests++; if (fim_count !== 1 || en_count !== 1) begin
         failed++; $display("FAIL hold_pulses got fim=%0d en=%0d want 1/1", fim_count, en_count);
      end
      tests++; if (fim_cycle !== 19) begin failed++; $display("FAIL hold_fim_cycle got %0d want 19", fim_cycle); end
   endtask

   task automatic test_reset_mid();
      int late;
      @(negedge clk);
      Inicio = 1'b1; dividendo = 16'd1000; divisor = 16'd3;
      @(posedge clk);
      // Cycle 9 is the eighth DIVIDE iteration; reset is sampled at its closing edge.
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         Inicio = 1'b0;
         if (c == 9) resetDiv_n = 1'b0;
      end
      @(negedge clk);
      resetDiv_n = 1'b1;
      tests++; if ({Ocupado, Fim, ErroDiv0, EnResto, EnQuociente} !== 5'b0) begin
         failed++; $display("FAIL midreset_status got %b want 00000",
                            {Ocupado, Fim, ErroDiv0, EnResto, EnQuociente});
      end
      tests++; if (quociente !== 16'h0 || resto !== 16'h0) begin
         failed++; $display("FAIL midreset_data got q=%h r=%h want 0/0", quociente, resto);
      end
      late = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (Ocupado !== 1'b0 || Fim !== 1'b0 || EnResto !== 1'b0) late++;
      end
      tests++; if (late !== 0) begin failed++; $display("FAIL midreset_aborted got %0d active cycles want 0", late); end
   endtask

   initial begin
      tests = 0; failed = 0;
      resetDiv_n = 1'b0; Inicio = 1'b0; dividendo = '0; divisor = '0;
      test_reset();
      test_basic();
      test_wide_divisor();
      test_back_to_back();
      test_div_zero();
      test_hold_inicio();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
